// File: rtl/mode_transition_controller_pkg.sv
// Shared types and helpers for the exhaust-hood mode transition controller.
// State encoding, default mode encodings and counter sizing live here.
package mode_transition_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int DEFAULT_MODE_WIDTH = 3;
  localparam int DEFAULT_NUM_MODES  = 5;
  localparam logic [DEFAULT_MODE_WIDTH-1:0] FIRST_MODE = 3'd0;
  localparam logic [DEFAULT_MODE_WIDTH-1:0] LAST_MODE  = 3'd4;

  // Width able to hold the larger of the two saturating counts.
  function automatic int cnt_width(input int hold, input int cool);
    int m;
    m = (hold > cool) ? hold : cool;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mode_transition_controller_toggle_edge_detector.sv
// Rising-edge detector for the debounced operator toggle level.
module toggle_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic toggle_d_r;

  // One-cycle delay of the button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_d_r <= 1'b0;
    end else begin
      toggle_d_r <= level;
    end
  end

  assign rise = level & ~toggle_d_r;

endmodule

// File: rtl/mode_transition_controller.sv
// Mode-step request generator: qualifies a toggle press and emits one request pulse.
// Optional long-press hold stage is built when MODE_TRANSITION_LONG_PRESS_EN is defined.
module mode_transition_controller
  import mode_transition_controller_pkg::*;
#(
  parameter int                   MODE_WIDTH      = 3,
  parameter int                   NUM_MODES       = 5,
  parameter logic [NUM_MODES-1:0] SRC_MASK        = {NUM_MODES{1'b1}},
  parameter int                   STEP_UP         = 1,
  parameter int                   HOLD_CYCLES     = 4,
  parameter int                   COOLDOWN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic                  toggle_signal,
  output logic                  transition_req,
  output logic [MODE_WIDTH-1:0] transition_target,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0]          COOL_MAX     = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [MODE_WIDTH:0]       NUM_MODES_W  = (MODE_WIDTH+1)'(NUM_MODES);
  localparam logic [MODE_WIDTH-1:0]     LAST_MODE_W  = MODE_WIDTH'(NUM_MODES - 1);
  localparam logic [2**MODE_WIDTH-1:0]  SRC_MASK_EXT = (2**MODE_WIDTH)'(SRC_MASK);

  // Wrapped neighbour of a mode in the configured step direction.
  function automatic logic [MODE_WIDTH-1:0] step_mode(input logic [MODE_WIDTH-1:0] m);
    logic [MODE_WIDTH-1:0] r;
    if (STEP_UP != 0) begin
      r = (m == LAST_MODE_W) ? {MODE_WIDTH{1'b0}} : m + MODE_WIDTH'(1);
    end else begin
      r = (m == {MODE_WIDTH{1'b0}}) ? LAST_MODE_W : m - MODE_WIDTH'(1);
    end
    return r;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cool_cnt_r, cool_cnt_s;
  logic [MODE_WIDTH-1:0] target_s;
  logic                  rise_s;
  logic                  mode_ok_s;

`ifdef MODE_TRANSITION_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  logic [CNT_W-1:0]      hold_cnt_r, hold_cnt_s;
  logic [MODE_WIDTH-1:0] armed_mode_r, armed_mode_s;
`endif

  toggle_edge_detector u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (toggle_signal),
    .rise  (rise_s)
  );

  // Out-of-range modes fail the range test before the mask is consulted.
  assign mode_ok_s = ({1'b0, current_mode} < NUM_MODES_W) & SRC_MASK_EXT[current_mode];

  // Next-state, counter and target selection.
  always_comb begin
    state_s    = state_r;
    cool_cnt_s = cool_cnt_r;
    target_s   = transition_target;
`ifdef MODE_TRANSITION_LONG_PRESS_EN
    hold_cnt_s   = hold_cnt_r;
    armed_mode_s = armed_mode_r;
`endif
    case (state_r)
      IDLE: begin
        if (rise_s && mode_ok_s) begin
`ifdef MODE_TRANSITION_LONG_PRESS_EN
          state_s      = ARMED;
          armed_mode_s = current_mode;
          hold_cnt_s   = {CNT_W{1'b0}};
`else
          state_s  = FIRE;
          target_s = step_mode(current_mode);
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef MODE_TRANSITION_LONG_PRESS_EN
      ARMED: begin
        if (!toggle_signal) begin
          state_s = IDLE;
        end else if (current_mode != armed_mode_r) begin
          state_s = IDLE;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s  = FIRE;
          target_s = step_mode(armed_mode_r);
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end
      end
`endif
      FIRE: begin
        state_s    = COOLDOWN;
        cool_cnt_s = {CNT_W{1'b0}};
      end
      COOLDOWN: begin
        // A still-held button keeps us here so one press yields one request.
        if ((cool_cnt_r >= COOL_MAX) && !toggle_signal) begin
          state_s = IDLE;
        end else if (cool_cnt_r < COOL_MAX) begin
          cool_cnt_s = cool_cnt_r + CNT_W'(1);
        end else begin
          cool_cnt_s = cool_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      cool_cnt_r        <= {CNT_W{1'b0}};
      transition_req    <= 1'b0;
      transition_target <= {MODE_WIDTH{1'b0}};
      busy              <= 1'b0;
`ifdef MODE_TRANSITION_LONG_PRESS_EN
      hold_cnt_r        <= {CNT_W{1'b0}};
      armed_mode_r      <= {MODE_WIDTH{1'b0}};
`endif
    end else begin
      state_r           <= state_s;
      cool_cnt_r        <= cool_cnt_s;
      transition_req    <= (state_s == FIRE);
      transition_target <= target_s;
      busy              <= (state_s != IDLE);
`ifdef MODE_TRANSITION_LONG_PRESS_EN
      hold_cnt_r        <= hold_cnt_s;
      armed_mode_r      <= armed_mode_s;
`endif
    end
  end

endmodule
